conv_tile_engine: RTL

Parametrised, loop-tiled 2-D convolution engine for the CNN datapath. Holds one input feature-map volume and one weight set in internal arrays, loaded through write ports. On `start` it computes every output pixel of every output channel with one signed multiply-accumulate per clock, walking the output plane in TR×TC tiles. Each finished pixel is streamed out on a valid/ready port tagged with its channel, row and column, with optional ReLU.

---
 rtl/conv_tile_engine.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/conv_tile_engine.sv
// Loop-tiled 2-D convolution engine: one signed multiply-accumulate per clock,
// each finished output pixel streamed on a valid/ready port with channel/row/col tags.
module conv_tile_engine #(
  parameter int unsigned DW    = 8,
  parameter int unsigned WW    = 8,
  parameter int unsigned AW    = 24,
  parameter int unsigned IN_H  = 11,
  parameter int unsigned IN_W  = 11,
  parameter int unsigned N_IN  = 3,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned K     = 3,
  parameter int unsigned S     = 2,
  parameter int unsigned TR    = 2,
  parameter int unsigned TC    = 2,
  localparam int unsigned OUT_H = (IN_H - K) / S + 1,
  localparam int unsigned OUT_W = (IN_W - K) / S + 1,
  localparam int unsigned XN    = N_IN * IN_H * IN_W,
  localparam int unsigned WN    = N_OUT * N_IN * K * K,
  localparam int unsigned XAW   = (XN > 1) ? $clog2(XN) : 1,
  localparam int unsigned WAW   = (WN > 1) ? $clog2(WN) : 1,
  localparam int unsigned CHW   = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int unsigned RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int unsigned CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_we,
  input  logic [XAW-1:0] in_addr,
  input  logic [DW-1:0]  in_data,
  input  logic           w_we,
  input  logic [WAW-1:0] w_addr,
  input  logic [WW-1:0]  w_data,
  input  logic           start,
  input  logic           relu_en,
  output logic           busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [AW-1:0]  out_data,
  output logic [CHW-1:0] out_ch,
  output logic [RW-1:0]  out_row,
  output logic [CW-1:0]  out_col,
  output logic           done
);

  localparam int unsigned TRW = (TR > 1) ? $clog2(TR) : 1;
  localparam int unsigned TCW = (TC > 1) ? $clog2(TC) : 1;
  localparam int unsigned TIW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned KW  = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {StIdle, StMac, StEmit, StDone} state_e;

  state_e state_q;

  logic signed [DW-1:0] x_mem [XN];
  logic signed [WW-1:0] w_mem [WN];

  logic [CHW-1:0] oc_q;
  logic [RW-1:0]  br_q;
  logic [CW-1:0]  bc_q;
  logic [TRW-1:0] trr_q;
  logic [TCW-1:0] tcc_q;
  logic [TIW-1:0] ti_q;
  logic [KW-1:0]  i_q, j_q;
  logic signed [AW-1:0] acc_q;
  logic relu_q;

  int unsigned r_n, c_n;
  logic [XAW-1:0] x_idx;
  logic [WAW-1:0] w_idx;
  logic signed [DW-1:0]    x_rd;
  logic signed [WW-1:0]    w_rd;
  logic signed [DW+WW-1:0] prod;
  logic signed [AW-1:0]    acc_sum;
  logic last_ti, last_tcc, last_trr, last_bc, last_br, last_oc, last_pix;

  // Arrays only change while idle, so a run always sees a stable operand set.
  always_ff @(posedge clk) begin
    if (in_we && state_q == StIdle) x_mem[in_addr] <= in_data;
    if (w_we && state_q == StIdle)  w_mem[w_addr] <= w_data;
  end

  always_comb begin
    r_n   = 32'(br_q) + 32'(trr_q);
    c_n   = 32'(bc_q) + 32'(tcc_q);
    x_idx = XAW'(32'(ti_q) * IN_H * IN_W + (S * r_n + 32'(i_q)) * IN_W + S * c_n + 32'(j_q));
    w_idx = WAW'(((32'(oc_q) * N_IN + 32'(ti_q)) * K + 32'(i_q)) * K + 32'(j_q));
    x_rd  = x_mem[x_idx];
    w_rd  = w_mem[w_idx];
    prod    = (DW+WW)'(x_rd) * (DW+WW)'(w_rd);
    acc_sum = acc_q + AW'(prod);
    last_ti  = (ti_q == TIW'(N_IN - 1));
    last_tcc = (32'(tcc_q) == TC - 1) || (c_n == OUT_W - 1);
    last_trr = (32'(trr_q) == TR - 1) || (r_n == OUT_H - 1);
    last_bc  = (32'(bc_q) + TC >= OUT_W);
    last_br  = (32'(br_q) + TR >= OUT_H);
    last_oc  = (32'(oc_q) == N_OUT - 1);
    last_pix = last_tcc && last_trr && last_bc && last_br && last_oc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_row   <= '0;
      out_col   <= '0;
      done      <= 1'b0;
      relu_q    <= 1'b0;
      oc_q      <= '0;
      br_q      <= '0;
      bc_q      <= '0;
      trr_q     <= '0;
      tcc_q     <= '0;
      ti_q      <= '0;
      i_q       <= '0;
      j_q       <= '0;
      acc_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            relu_q  <= relu_en;
            oc_q    <= '0;
            br_q    <= '0;
            bc_q    <= '0;
            trr_q   <= '0;
            tcc_q   <= '0;
            ti_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            busy    <= 1'b1;
            state_q <= StMac;
          end
        end
        StMac: begin
          acc_q <= acc_sum;
          if (j_q != KW'(K - 1)) begin
            j_q <= j_q + KW'(1);
          end else begin
            j_q <= '0;
            if (i_q != KW'(K - 1)) begin
              i_q <= i_q + KW'(1);
            end else begin
              i_q <= '0;
              if (!last_ti) begin
                ti_q <= ti_q + TIW'(1);
              end else begin
                ti_q      <= '0;
                out_valid <= 1'b1;
                out_data  <= (relu_q && acc_sum[AW-1]) ? '0 : acc_sum;
                out_ch    <= oc_q;
                out_row   <= RW'(r_n);
                out_col   <= CW'(c_n);
                state_q   <= StEmit;
              end
            end
          end
        end
        StEmit: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc_q     <= '0;
            done      <= last_pix;
            state_q   <= last_pix ? StDone : StMac;
            // Odometer over (oc, base_r, base_c, trr, tcc) with edge-tile clipping.
            if (!last_tcc) begin
              tcc_q <= tcc_q + TCW'(1);
            end else begin
              tcc_q <= '0;
              if (!last_trr) begin
                trr_q <= trr_q + TRW'(1);
              end else begin
                trr_q <= '0;
                if (!last_bc) begin
                  bc_q <= bc_q + CW'(TC);
                end else begin
                  bc_q <= '0;
                  if (!last_br) begin
                    br_q <= br_q + RW'(TR);
                  end else begin
                    br_q <= '0;
                    oc_q <= last_oc ? '0 : oc_q + CHW'(1);
                  end
                end
              end
            end
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
